// File: rtl/restoring_divider_8bit_if.sv
// Handshake bundle for the restoring divider.
//   master: operand producer / result consumer (drives in_valid, dividend,
//           divisor, out_ready; observes in_ready, out_valid, quotient,
//           remainder, dbz)
//   slave : the divider itself
interface restoring_divider_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );
endinterface

// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Operands enter on a valid/ready handshake, quotient/remainder leave on a
// second valid/ready handshake; one operation in flight at a time.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : restoring_divider_8bit_if.slave
//          in_valid/in_ready/dividend/divisor   operand side
//          out_valid/out_ready/quotient/remainder/dbz  result side
// Optional feature: define DIV_BY_ZERO_DETECT_EN to short-circuit a zero
// divisor straight to DONE with dbz=1; otherwise dbz is tied low and a zero
// divisor runs the normal iteration (which yields q=all ones, r=dividend).
module restoring_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    restoring_divider_8bit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rem_acc_q, rem_acc_d;
    logic [WIDTH-1:0]   q_acc_q, q_acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef DIV_BY_ZERO_DETECT_EN
    logic               dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0]   shift_rem;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH:0]     trial;

    // Next-state, datapath step and registered-output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_acc_d   = rem_acc_q;
        q_acc_d     = q_acc_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_BY_ZERO_DETECT_EN
        dbz_d       = dbz_q;
`endif

        // {rem_acc,q_acc} << 1; rem_acc stays below 2^(step) so no bit is lost
        shift_rem = {rem_acc_q[WIDTH-2:0], q_acc_q[WIDTH-1]};
        shift_q   = {q_acc_q[WIDTH-2:0], 1'b0};
        // MSB of trial is the borrow of the trial subtraction
        trial     = {1'b0, shift_rem} - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    rem_acc_d = '0;
                    q_acc_d   = bus.dividend;
                    dvs_d     = bus.divisor;
                    count_d   = '0;
`ifdef DIV_BY_ZERO_DETECT_EN
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end

            BUSY: begin
                if (count_q == CNT_W'(WIDTH)) begin
                    // all WIDTH bits resolved: publish the accumulators
                    quotient_d  = q_acc_q;
                    remainder_d = rem_acc_q;
                    state_d     = DONE;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_acc_d = trial[WIDTH-1:0];
                        q_acc_d   = shift_q | WIDTH'(1);
                    end else begin
                        rem_acc_d = shift_rem;
                        q_acc_d   = shift_q;
                    end
                    count_d = count_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_acc_q   <= '0;
            q_acc_q     <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_acc_q   <= rem_acc_d;
            q_acc_q     <= q_acc_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIV_BY_ZERO_DETECT_EN
    assign bus.dbz       = dbz_q;
`else
    assign bus.dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Self-checking bench for restoring_divider_8bit: directed vector table,
// back-pressure and mid-operation reset sequences, and a random sweep.
module tb_restoring_divider_8bit;
    localparam int LIMIT = 50;
`ifdef DIV_BY_ZERO_DETECT_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    restoring_divider_8bit_if #(.WIDTH(8)) bus ();

    restoring_divider_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait (bounded) for in_ready, pass the accepting edge
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        while (!bus.in_ready && n < LIMIT) begin
            tick();
            n++;
        end
        check("in_ready_wait", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        // scramble the bus: operands must already be captured
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    // Count edges after the accepting edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < LIMIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        int   exp_lat;
        tests = 0;
        fails = 0;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0};
        vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77};
        vecs[5] = '{8'd100, 8'd10,  8'd10,  8'd0};
        vecs[6] = '{8'd9,   8'd2,   8'd4,   8'd1};
        vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0};
        vecs[8] = '{8'd128, 8'd127, 8'd1,   8'd1};
        vecs[9] = '{8'd1,   8'd255, 8'd0,   8'd1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_quotient",  int'(bus.quotient),  0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz",       int'(bus.dbz),       0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            // with detection a zero divisor is DONE straight after acceptance
            exp_lat = (DBZ_EN && vecs[i].b == 8'd0) ? 0 : 9;
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
            check($sformatf("vec%0d_q", i), int'(bus.quotient),  int'(vecs[i].exp_q));
            check($sformatf("vec%0d_r", i), int'(bus.remainder), int'(vecs[i].exp_r));
            check($sformatf("vec%0d_dbz", i), int'(bus.dbz),
                  (DBZ_EN && vecs[i].b == 8'd0) ? 1 : 0);
            finish_op();
            check($sformatf("vec%0d_in_ready_after", i), int'(bus.in_ready), 1);
        end

        // Back-pressure: result held while out_ready stays low
        start_op(8'd100, 8'd10);
        check("bp_busy_in_ready", int'(bus.in_ready), 0);
        wait_valid(lat);
        check("bp_latency", lat, 9);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_q", c), int'(bus.quotient), 10);
            check($sformatf("bp%0d_r", c), int'(bus.remainder), 0);
            check($sformatf("bp%0d_out_valid", c), int'(bus.out_valid), 1);
            check($sformatf("bp%0d_in_ready", c), int'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        check("bp_in_ready_same_cycle", int'(bus.in_ready), 0);
        tick();
        bus.out_ready = 1'b0;
        check("bp_in_ready_next", int'(bus.in_ready), 1);
        check("bp_out_valid_next", int'(bus.out_valid), 0);
        check("bp_idle_hold_q", int'(bus.quotient), 10);

        // Reset in the middle of 200/7
        start_op(8'd200, 8'd7);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  int'(bus.in_ready),  1);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_q",         int'(bus.quotient),  0);
        check("mid_rst_r",         int'(bus.remainder), 0);
        start_op(8'd9, 8'd2);
        wait_valid(lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_q", int'(bus.quotient),  4);
        check("post_rst_r", int'(bus.remainder), 1);
        finish_op();

        // Random sweep with random handshake gaps
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            int eq;
            int er;
            a = 8'($urandom);
            b = 8'($urandom);
            if (n % 50 == 0) b = 8'd0;
            if (b == 8'd0) begin
                eq = 255;
                er = int'(a);
            end else begin
                eq = int'(a) / int'(b);
                er = int'(a) % int'(b);
            end
            repeat ($urandom_range(0, 3)) tick();
            start_op(a, b);
            wait_valid(lat);
            if (lat >= LIMIT) check("rnd_timeout", lat, 9);
            repeat ($urandom_range(0, 3)) tick();
            if (int'(bus.quotient) != eq || int'(bus.remainder) != er) begin
                check($sformatf("rnd%0d_q(%0d/%0d)", n, a, b), int'(bus.quotient), eq);
                check($sformatf("rnd%0d_r(%0d/%0d)", n, a, b), int'(bus.remainder), er);
            end else begin
                check("rnd_q", int'(bus.quotient), eq);
                check("rnd_r", int'(bus.remainder), er);
            end
            check("rnd_dbz", int'(bus.dbz), (DBZ_EN && b == 8'd0) ? 1 : 0);
            finish_op();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
